angle_frame_tx: RTL and testbench

//   UART 8N1 transmitter sending one framed packet of the four servo angles:

---
 rtl/angle_frame_tx.sv | 180 ++++++++++++++++++
 tb/tb_angle_frame_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_frame_tx.sv
// UART 8N1 transmitter for the servo angle frame: header, four angle bytes and,
// when ANGLE_FRAME_CHECKSUM_EN is defined, an XOR checksum byte.
module angle_frame_tx #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [7:0]  HEADER       = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] angle_1,
    input  logic [7:0] angle_2,
    input  logic [7:0] angle_3,
    input  logic [7:0] angle_4,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef ANGLE_FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    function automatic logic [7:0] sanitise(input logic [7:0] b);
        if (b == HEADER) begin
            return HEADER - 8'd1;
        end else begin
            return b;
        end
    endfunction

    state_t        state_r, state_n;
    logic [BW-1:0] baud_r, baud_n;
    logic [2:0]    bit_r, bit_n;
    logic [2:0]    idx_r, idx_n;
    logic [7:0]    a1_r, a2_r, a3_r, a4_r;
    logic          tx_r, tx_n;
    logic          busy_r, busy_n;
    logic          done_r, done_n;
    logic          latch_s;
    logic [7:0]    byte_s;

    // Next-state logic; the NEXT decision is folded into the last STOP cycle
    // so the following start bit begins without a gap cycle.
    always_comb begin
        state_n = state_r;
        baud_n  = baud_r;
        bit_n   = bit_r;
        idx_n   = idx_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        latch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n = START;
                    baud_n  = {BW{1'b0}};
                    bit_n   = 3'd0;
                    idx_n   = 3'd0;
                    busy_n  = 1'b1;
                    latch_s = 1'b1;
                end else begin
                    busy_n  = 1'b0;
                end
            end
            START: begin
                if (baud_r == BAUD_LAST) begin
                    state_n = DATA;
                    baud_n  = {BW{1'b0}};
                end else begin
                    baud_n  = baud_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            DATA: begin
                if (baud_r == BAUD_LAST) begin
                    baud_n = {BW{1'b0}};
                    bit_n  = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    baud_n = baud_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            STOP: begin
                if (baud_r == BAUD_LAST) begin
                    baud_n = {BW{1'b0}};
                    if (idx_r == LAST_BYTE) begin
                        state_n = IDLE;
                        idx_n   = 3'd0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = START;
                        idx_n   = idx_r + 3'd1;
                    end
                end else begin
                    baud_n = baud_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Byte mux and line value for the upcoming cycle, so tx is registered.
    always_comb begin
        case (idx_n)
            3'd0:    byte_s = HEADER;
            3'd1:    byte_s = a1_r;
            3'd2:    byte_s = a2_r;
            3'd3:    byte_s = a3_r;
            3'd4:    byte_s = a4_r;
`ifdef ANGLE_FRAME_CHECKSUM_EN
            3'd5:    byte_s = sanitise(a1_r ^ a2_r ^ a3_r ^ a4_r);
`endif
            default: byte_s = HEADER;
        endcase
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = byte_s[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            idx_r   <= 3'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            baud_r  <= baud_n;
            bit_r   <= bit_n;
            idx_r   <= idx_n;
            tx_r    <= tx_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    // Angles are captured once per frame; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_r <= 8'd0;
            a2_r <= 8'd0;
            a3_r <= 8'd0;
            a4_r <= 8'd0;
        end else if (latch_s) begin
            a1_r <= sanitise(angle_1);
            a2_r <= sanitise(angle_2);
            a3_r <= sanitise(angle_3);
            a4_r <= sanitise(angle_4);
        end else begin
            a1_r <= a1_r;
            a2_r <= a2_r;
            a3_r <= a3_r;
            a4_r <= a4_r;
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_angle_frame_tx.sv
// Scoreboard bench for angle_frame_tx: a 4-cycle-per-bit instance and a
// 2-cycle-per-bit instance share clock and reset.
module tb_angle_frame_tx;

`ifdef ANGLE_FRAME_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, start2 = 1'b0;
    logic [7:0] a1, a2, a3, a4;
    logic tx1, busy1, done1, tx2, busy2, done2;

    int checks = 0;
    int failures = 0;
    int busy_seen;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    logic [7:0] exp_q[$];

    angle_frame_tx #(.CLKS_PER_BIT(4), .HEADER(8'hFF)) dut (
        .clk(clk), .rst(rst), .start(start1),
        .angle_1(a1), .angle_2(a2), .angle_3(a3), .angle_4(a4),
        .tx(tx1), .busy(busy1), .done(done1));

    angle_frame_tx #(.CLKS_PER_BIT(2), .HEADER(8'hFF)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .angle_1(a1), .angle_2(a2), .angle_3(a3), .angle_4(a4),
        .tx(tx2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
        if (done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
    end

    function automatic logic [7:0] san(input logic [7:0] b);
        return (b == 8'hFF) ? 8'hFE : b;
    endfunction

    task automatic push_frame(input logic [7:0] x1, x2, x3, x4);
        exp_q.push_back(8'hFF);
        exp_q.push_back(san(x1));
        exp_q.push_back(san(x2));
        exp_q.push_back(san(x3));
        exp_q.push_back(san(x4));
        if (NB == 6) exp_q.push_back(san(san(x1) ^ san(x2) ^ san(x3) ^ san(x4)));
    endtask

    // Drives a one-cycle start; returns at the first sample after acceptance.
    task automatic launch(input bit which, input logic [7:0] x1, x2, x3, x4);
        a1 = x1; a2 = x2; a3 = x3; a4 = x4;
        push_frame(x1, x2, x3, x4);
        if (which) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
    endtask

    // Samples one 10-bit character every cycle; bad counts unstable or misframed bits.
    task automatic rx_byte(input int cpb, input bit which, output logic [7:0] b, output int bad);
        logic v, first;
        bad = 0; b = 8'h00; first = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < cpb; c++) begin
                v = which ? tx2 : tx1;
                if ((which ? busy2 : busy1) === 1'b1) busy_seen++;
                if (c == 0) first = v;
                else if (v !== first) bad++;
                @(posedge clk); #1;
            end
            if (k == 0) begin
                if (first !== 1'b0) bad++;
            end else if (k == 9) begin
                if (first !== 1'b1) bad++;
            end else begin
                b[k-1] = first;
            end
        end
    endtask

    task automatic rx_frame(input int cpb, input bit which, input string tag);
        logic [7:0] got, exp;
        int bad;
        busy_seen = 0;
        for (int i = 0; i < NB; i++) begin
            rx_byte(cpb, which, got, bad);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            checks++;
            if (got !== exp || bad != 0) begin
                failures++;
                $display("FAIL %s byte%0d: got %h (bit errors %0d) expected %h", tag, i, got, bad, exp);
            end
        end
        checks++;
        if (busy_seen != NB * 10 * cpb) begin
            failures++;
            $display("FAIL %s busy_len: got %0d expected %0d", tag, busy_seen, NB * 10 * cpb);
        end
        checks++;
        if ((which ? done2 : done1) !== 1'b1 || (which ? busy2 : busy1) !== 1'b0 || (which ? tx2 : tx1) !== 1'b1) begin
            failures++;
            $display("FAIL %s end: done=%b busy=%b tx=%b expected done=1 busy=0 tx=1",
                     tag, which ? done2 : done1, which ? busy2 : busy1, which ? tx2 : tx1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b expected 1 0 0", tx1, busy1, done1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        launch(1'b0, 8'h11, 8'h00, 8'h22, 8'h33);
        repeat (96) @(posedge clk);
        #1;
        checks++;
        if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre: tx=%b busy=%b expected 0 1", tx1, busy1);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: tx=%b busy=%b done=%b expected 1 0 0", tx1, busy1, done1);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        launch(1'b0, 8'h01, 8'h80, 8'h7E, 8'hC3);
        rx_frame(4, 1'b0, "reset_fresh");
    endtask

    task automatic test_basic();
        int d0;
        @(posedge clk); #1;
        d0 = done_cnt1;
        launch(1'b0, 8'd90, 8'd45, 8'd180, 8'd0);
        rx_frame(4, 1'b0, "basic");
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b0 || done_cnt1 - d0 != 1) begin
            failures++;
            $display("FAIL basic_done: pulses=%0d done=%b expected 1 pulse then 0", done_cnt1 - d0, done1);
        end
    endtask

    task automatic test_sanitise();
        @(posedge clk); #1;
        launch(1'b0, 8'd90, 8'd45, 8'hFF, 8'd0);
        rx_frame(4, 1'b0, "sanitise");
    endtask

    task automatic test_ignore_start();
        int d0;
        @(posedge clk); #1;
        d0 = done_cnt1;
        launch(1'b0, 8'h5A, 8'h2D, 8'hB4, 8'h00);
        fork
            rx_frame(4, 1'b0, "ignore");
            begin
                repeat (10) @(posedge clk);
                #1;
                start1 = 1'b1; a1 = 8'h12; a2 = 8'h34; a3 = 8'h56; a4 = 8'h78;
                @(posedge clk); #1;
                start1 = 1'b0;
                repeat (139) @(posedge clk);
                #1;
                start1 = 1'b1; a1 = 8'h9A;
                @(posedge clk); #1;
                start1 = 1'b0;
            end
        join
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
                failures++;
                $display("FAIL ignore_idle%0d: tx=%b busy=%b expected 1 0", i, tx1, busy1);
            end
        end
        checks++;
        if (done_cnt1 - d0 != 1) begin
            failures++;
            $display("FAIL ignore_done: pulses=%0d expected 1", done_cnt1 - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        @(posedge clk); #1;
        d0 = done_cnt1;
        a1 = 8'h0F; a2 = 8'hF0; a3 = 8'hAA; a4 = 8'h55;
        push_frame(a1, a2, a3, a4);
        push_frame(a1, a2, a3, a4);
        start1 = 1'b1;
        @(posedge clk); #1;
        rx_frame(4, 1'b0, "b2b_first");
        @(posedge clk); #1;
        start1 = 1'b0;
        rx_frame(4, 1'b0, "b2b_second");
        @(posedge clk); #1;
        checks++;
        if (done_cnt1 - d0 != 2 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: pulses=%0d busy=%b expected 2 0", done_cnt1 - d0, busy1);
        end
    endtask

    task automatic test_fast_baud();
        int d0;
        @(posedge clk); #1;
        d0 = done_cnt2;
        launch(1'b1, 8'hA5, 8'h3C, 8'hFF, 8'h81);
        rx_frame(2, 1'b1, "cpb2");
        @(posedge clk); #1;
        checks++;
        if (done_cnt2 - d0 != 1) begin
            failures++;
            $display("FAIL cpb2_done: pulses=%0d expected 1", done_cnt2 - d0);
        end
    endtask

    initial begin
        a1 = 8'h00; a2 = 8'h00; a3 = 8'h00; a4 = 8'h00;
        test_reset();
        test_basic();
        test_sanitise();
        test_ignore_start();
        test_back_to_back();
        test_fast_baud();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
